// File: rtl/cnt_run_pkg.sv
// Shared types and constants for the cnt_run_arb counter-sharing controller.
package cnt_run_pkg;

  localparam int NREQ      = 2;
  localparam int WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/upcnt_core.sv
// WIDTH-bit synchronous up counter; clr has priority over en.
module upcnt_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/cnt_run_arb.sv
// Two-requester arbiter sharing one run timer; round-robin by default,
// fixed priority to requester 0 when CNT_RUN_FIXED_PRIO_EN is defined.
module cnt_run_arb
  import cnt_run_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [WIDTH-1:0] count_out
);

  state_e           state_q, state_d;
  logic             win_q, win_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             pick;
  logic             cnt_clr;
  logic             cnt_en;

`ifdef CNT_RUN_FIXED_PRIO_EN
  assign pick = ~req[0];
`else
  logic last_q, last_d;

  // On a conflict the requester not served last wins.
  assign pick = (req == 2'b11) ? ~last_q : req[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
`ifndef CNT_RUN_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
`ifndef CNT_RUN_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
    win_q <= win_d;
    tgt_q <= tgt_d;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    tgt_d   = tgt_q;
`ifndef CNT_RUN_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d = RUN;
          win_d   = pick;
          tgt_d   = pick ? len1 : len0;
        end
      end
      RUN: begin
        // A dropped request aborts even when the terminal count is reached.
        if (!req[win_q]) begin
          state_d = IDLE;
        end else if (count_out == tgt_q) begin
          state_d = DONE;
`ifndef CNT_RUN_FIXED_PRIO_EN
          last_d  = win_q;
`endif
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) begin
      cnt_clr = 1'b1;
    end
  end

  always_comb begin
    gnt  = '0;
    done = '0;
    busy = 1'b0;
    case (state_q)
      RUN: begin
        gnt[win_q] = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        done[win_q] = 1'b1;
        busy        = 1'b1;
      end
      default: ;
    endcase
  end

  upcnt_core #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk      (clk),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .count_out(count_out)
  );

endmodule

// File: tb/tb_cnt_run_arb.sv
// Directed bench for cnt_run_arb; expectations follow the default or
// CNT_RUN_FIXED_PRIO_EN build depending on the macro.
module tb_cnt_run_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [2:0] len0;
  logic [2:0] len1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [2:0] count_out;

  int checks = 0;
  int errors = 0;

  cnt_run_arb #(.WIDTH(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .len0     (len0),
    .len1     (len1),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects a grant on the next edge, then a full run of length n and the done/idle tail.
  task automatic run_expect(input logic [1:0] g, input int n);
    tick();
    check("grant_gnt", int'(gnt), int'(g));
    check("grant_cnt", int'(count_out), 0);
    check("grant_busy", int'(busy), 1);
    for (int i = 1; i <= n; i++) begin
      tick();
      check("run_cnt", int'(count_out), i);
      check("run_gnt", int'(gnt), int'(g));
      check("run_done", int'(done), 0);
    end
    tick();
    check("done_pulse", int'(done), int'(g));
    check("done_gnt", int'(gnt), 0);
    check("done_cnt", int'(count_out), 0);
    check("done_busy", int'(busy), 1);
    tick();
    check("idle_done", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_gnt", int'(gnt), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    repeat (5) tick();
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(count_out), 0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    len0 = 3'd0;
    len1 = 3'd0;

    // Single request, len0=3.
    do_reset();
    req  = 2'b01;
    len0 = 3'd3;
    run_expect(2'b01, 3);
    req = 2'b00;
    tick();
    check("t1_idle", int'(gnt), 0);

    // Both held from reset: 0, then 1, then 0 again (fixed priority: always 0).
    do_reset();
    req  = 2'b11;
    len0 = 3'd2;
    len1 = 3'd5;
    run_expect(2'b01, 2);
`ifdef CNT_RUN_FIXED_PRIO_EN
    run_expect(2'b01, 2);
`else
    run_expect(2'b10, 5);
`endif
    run_expect(2'b01, 2);
    req = 2'b00;
    tick();

    // len1=0 gives a single RUN cycle.
    req  = 2'b10;
    len1 = 3'd0;
    run_expect(2'b10, 0);
    req = 2'b00;
    tick();

    // Serve requester 0 so a later conflict favours requester 1.
    req  = 2'b01;
    len0 = 3'd0;
    run_expect(2'b01, 0);
    req = 2'b00;
    tick();

    // Abort at count 2 of a len0=6 run.
    req  = 2'b01;
    len0 = 3'd6;
    tick();
    check("ab_gnt", int'(gnt), 1);
    tick();
    tick();
    check("ab_cnt2", int'(count_out), 2);
    req = 2'b00;
    tick();
    check("ab_gnt0", int'(gnt), 0);
    check("ab_cnt0", int'(count_out), 0);
    check("ab_done", int'(done), 0);
    check("ab_busy", int'(busy), 0);
    req = 2'b11;
    tick();
`ifdef CNT_RUN_FIXED_PRIO_EN
    check("ab_next", int'(gnt), 1);
`else
    check("ab_next", int'(gnt), 2);
`endif
    check("ab_next_done", int'(done), 0);
    req = 2'b00;
    tick();
    tick();

    // Reset at count 4 of a len0=7 run.
    req  = 2'b01;
    len0 = 3'd7;
    repeat (5) tick();
    check("rs_cnt4", int'(count_out), 4);
    reset = 1'b1;
    tick();
    check("rs_gnt", int'(gnt), 0);
    check("rs_done", int'(done), 0);
    check("rs_busy", int'(busy), 0);
    check("rs_cnt", int'(count_out), 0);
    reset = 1'b0;
    req   = 2'b11;
    tick();
    check("rs_conflict", int'(gnt), 1);
    req = 2'b00;
    tick();
    tick();

    // len0 change mid-run is ignored.
    req  = 2'b01;
    len0 = 3'd2;
    tick();
    check("ln_gnt", int'(gnt), 1);
    len0 = 3'd7;
    tick();
    check("ln_cnt1", int'(count_out), 1);
    tick();
    check("ln_cnt2", int'(count_out), 2);
    tick();
    check("ln_done", int'(done), 1);
    check("ln_cnt0", int'(count_out), 0);
    req = 2'b00;
    tick();
    check("ln_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
